// File: rtl/uart_fifo_px.sv
// UART core with TX/RX FIFOs, runtime parity selection, 3-sample majority-vote
// reception and sticky parity/framing/overrun flags.

module uart_fifo_px_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    logic         do_push, do_pop;

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end
endmodule

module uart_fifo_px #(
    parameter int WIDTH_DATA = 8,
    parameter int NB_STOP    = 1,
    parameter int CLK_SIZE   = 434,
    parameter int WIDTH_CLK  = $clog2(CLK_SIZE),
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  i_rx,
    output logic                  o_tx,
    input  logic [WIDTH_DATA-1:0] i_data,
    input  logic                  i_we,
    output logic                  o_full,
    output logic                  o_mty,
    output logic [WIDTH_DATA-1:0] o_data,
    output logic                  o_rdy,
    input  logic                  i_re,
    input  logic [1:0]            i_par,
    input  logic                  i_clr_err,
    output logic                  o_perr,
    output logic                  o_ferr,
    output logic                  o_ovr,
    output logic [2:0]            o_dbg_tx_state,
    output logic [2:0]            o_dbg_rx_state
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    localparam logic [WIDTH_CLK-1:0] CNT_MAX = WIDTH_CLK'(CLK_SIZE - 1);
    localparam logic [WIDTH_CLK-1:0] SMP0    = WIDTH_CLK'(CLK_SIZE / 2 - 1);
    localparam logic [WIDTH_CLK-1:0] SMP1    = WIDTH_CLK'(CLK_SIZE / 2);
    localparam logic [WIDTH_CLK-1:0] SMP2    = WIDTH_CLK'(CLK_SIZE / 2 + 1);
    localparam logic [3:0]           DATA_LAST = 4'(WIDTH_DATA - 1);
    localparam logic [3:0]           STOP_LAST = 4'(NB_STOP - 1);

    function automatic logic par_bit(input logic [1:0] mode, input logic [WIDTH_DATA-1:0] d);
        case (mode)
            2'b01:   return ^d;
            2'b10:   return ~^d;
            default: return 1'b1;
        endcase
    endfunction

    // ---------------- transmitter ----------------
    state_t                  tx_state, tx_next;
    logic [WIDTH_CLK-1:0]    tx_cnt;
    logic [3:0]              tx_bit;
    logic [WIDTH_DATA-1:0]   tx_sh, tx_head;
    logic [1:0]              tx_mode;
    logic                    tx_pbit, tx_tick, tx_pop, tx_empty, tx_line;

    uart_fifo_px_fifo #(.W(WIDTH_DATA), .DEPTH(DEPTH)) u_tx_fifo (
        .clk(clk), .nrst(nrst), .push(i_we), .pop(tx_pop), .din(i_data),
        .dout(tx_head), .full(o_full), .empty(tx_empty)
    );

    assign tx_tick = (tx_cnt == CNT_MAX);
    // The head stays queued through the start bit and is popped as DATA begins.
    assign tx_pop  = (tx_state == S_START) && tx_tick;

    always_comb begin
        tx_next = tx_state;
        tx_line = 1'b1;
        case (tx_state)
            S_IDLE:  if (!tx_empty) tx_next = S_START;
            S_START: begin
                tx_line = 1'b0;
                if (tx_tick) tx_next = S_DATA;
            end
            S_DATA: begin
                tx_line = tx_sh[0];
                if (tx_tick && tx_bit == DATA_LAST) tx_next = (tx_mode == 2'b00) ? S_STOP : S_PAR;
            end
            S_PAR: begin
                tx_line = tx_pbit;
                if (tx_tick) tx_next = S_STOP;
            end
            S_STOP:  if (tx_tick && tx_bit == STOP_LAST) tx_next = tx_empty ? S_IDLE : S_START;
            default: tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_mode  <= 2'b00;
            tx_pbit  <= 1'b0;
            o_tx     <= 1'b1;
            o_mty    <= 1'b1;
        end else begin
            tx_state <= tx_next;
            tx_cnt   <= (tx_state == S_IDLE || tx_tick) ? '0 : tx_cnt + WIDTH_CLK'(1);
            if (tx_next != tx_state) tx_bit <= '0;
            else if (tx_tick)        tx_bit <= tx_bit + 4'd1;
            if (tx_pop) begin
                tx_sh   <= tx_head;
                tx_pbit <= par_bit(tx_mode, tx_head);
            end else if (tx_state == S_DATA && tx_tick) begin
                tx_sh <= tx_sh >> 1;
            end
            if (tx_next == S_START && tx_state != S_START) tx_mode <= i_par;
            o_tx  <= tx_line;
            o_mty <= (tx_state == S_IDLE) && tx_empty;
        end
    end

    // ---------------- receiver ----------------
    state_t                  rx_state, rx_next;
    logic [WIDTH_CLK-1:0]    rx_cnt;
    logic [3:0]              rx_bit;
    logic [WIDTH_DATA-1:0]   rx_sh, rx_head;
    logic [1:0]              rx_mode;
    logic                    rx_s1, rx_s2, rx_d, smp0, smp1;
    logic                    rx_fall, rx_tick, rx_vote, rx_maj, rx_push, rx_full, rx_empty;
    logic                    set_perr, set_ferr, set_ovr;

    uart_fifo_px_fifo #(.W(WIDTH_DATA), .DEPTH(DEPTH)) u_rx_fifo (
        .clk(clk), .nrst(nrst), .push(rx_push), .pop(i_re), .din(rx_sh),
        .dout(rx_head), .full(rx_full), .empty(rx_empty)
    );

    // Sync flops reset low so a line already low after reset never looks like an edge.
    assign rx_fall  = rx_d && !rx_s2;
    assign rx_tick  = (rx_cnt == CNT_MAX);
    assign rx_vote  = (rx_cnt == SMP2);
    assign rx_maj   = (smp0 & smp1) | (smp0 & rx_s2) | (smp1 & rx_s2);
    assign rx_push  = (rx_state == S_STOP) && rx_vote;
    assign set_perr = (rx_state == S_PAR) && rx_vote && (rx_maj != par_bit(rx_mode, rx_sh));
    assign set_ferr = rx_push && !rx_maj;
    assign set_ovr  = rx_push && rx_full;
    assign o_rdy    = !rx_empty;
    assign o_data   = rx_empty ? '0 : rx_head;

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            S_IDLE:  if (rx_fall) rx_next = S_START;
            S_START: begin
                if (rx_vote && rx_maj) rx_next = S_IDLE;
                else if (rx_tick)      rx_next = S_DATA;
            end
            S_DATA:  if (rx_tick && rx_bit == DATA_LAST) rx_next = (rx_mode == 2'b00) ? S_STOP : S_PAR;
            S_PAR:   if (rx_tick) rx_next = S_STOP;
            S_STOP:  if (rx_vote) rx_next = S_IDLE;
            default: rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_s1    <= 1'b0;
            rx_s2    <= 1'b0;
            rx_d     <= 1'b0;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_mode  <= 2'b00;
            smp0     <= 1'b1;
            smp1     <= 1'b1;
            o_perr   <= 1'b0;
            o_ferr   <= 1'b0;
            o_ovr    <= 1'b0;
        end else begin
            rx_s1    <= i_rx;
            rx_s2    <= rx_s1;
            rx_d     <= rx_s2;
            rx_state <= rx_next;
            rx_cnt   <= (rx_state == S_IDLE || rx_tick) ? '0 : rx_cnt + WIDTH_CLK'(1);
            if (rx_next != rx_state) rx_bit <= '0;
            else if (rx_tick)        rx_bit <= rx_bit + 4'd1;
            if (rx_cnt == SMP0) smp0 <= rx_s2;
            if (rx_cnt == SMP1) smp1 <= rx_s2;
            if (rx_state == S_DATA && rx_vote) rx_sh <= {rx_maj, rx_sh[WIDTH_DATA-1:1]};
            if (rx_state == S_START && rx_vote && !rx_maj) rx_mode <= i_par;
            o_perr <= set_perr | (o_perr & ~i_clr_err);
            o_ferr <= set_ferr | (o_ferr & ~i_clr_err);
            o_ovr  <= set_ovr  | (o_ovr  & ~i_clr_err);
        end
    end

    assign o_dbg_tx_state = tx_state;
    assign o_dbg_rx_state = rx_state;
endmodule

// File: tb/tb_uart_fifo_px.sv
// Bench for uart_fifo_px: TX timing/FIFO, loopback, RX error flags, overrun, reset.
module tb_uart_fifo_px;
    localparam int WD  = 8;
    localparam int NS  = 1;
    localparam int CS  = 16;
    localparam int DEP = 4;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          i_rx, o_tx;
    logic [WD-1:0] i_data = '0, o_data;
    logic          i_we = 1'b0, o_full, o_mty, o_rdy, i_re = 1'b0;
    logic [1:0]    i_par = 2'b00;
    logic          i_clr_err = 1'b0, o_perr, o_ferr, o_ovr;
    logic [2:0]    dbg_tx, dbg_rx;
    logic          rx_src = 1'b0;
    logic          rx_drv = 1'b1;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [WD-1:0] exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign i_rx = rx_src ? o_tx : rx_drv;

    uart_fifo_px #(.WIDTH_DATA(WD), .NB_STOP(NS), .CLK_SIZE(CS), .DEPTH(DEP)) dut (
        .clk(clk), .nrst(nrst), .i_rx(i_rx), .o_tx(o_tx), .i_data(i_data), .i_we(i_we),
        .o_full(o_full), .o_mty(o_mty), .o_data(o_data), .o_rdy(o_rdy), .i_re(i_re),
        .i_par(i_par), .i_clr_err(i_clr_err), .o_perr(o_perr), .o_ferr(o_ferr), .o_ovr(o_ovr),
        .o_dbg_tx_state(dbg_tx), .o_dbg_rx_state(dbg_rx)
    );

    // Parity bit from the frame rules: even/odd count of ones, mark is always 1.
    function automatic logic ref_par(input logic [1:0] m, input logic [WD-1:0] d);
        case (m)
            2'b01:   return ($countones(d) % 2) == 1;
            2'b10:   return ($countones(d) % 2) == 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int frame_len(input logic [1:0] m);
        return CS * (1 + WD + ((m != 2'b00) ? 1 : 0) + NS);
    endfunction

    task automatic write_byte(input logic [WD-1:0] d);
        @(negedge clk); i_data = d; i_we = 1'b1;
        @(negedge clk); i_we = 1'b0;
    endtask

    task automatic pop_rx();
        i_re = 1'b1;
        @(negedge clk); i_re = 1'b0;
    endtask

    task automatic clear_err();
        @(negedge clk); i_clr_err = 1'b1;
        @(negedge clk); i_clr_err = 1'b0;
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (o_rdy !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    endtask

    // Decodes one frame from o_tx by sampling each bit near its middle.
    task automatic rx_line(input logic [1:0] m, output logic [WD-1:0] d, output logic pb,
                           output logic sb, output int start_cyc, output logic to);
        int n = 0;
        d = '0; pb = 1'b0; to = 1'b0;
        while (o_tx !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
        if (n >= 4000) to = 1'b1;
        start_cyc = cyc;
        repeat (CS / 2) @(negedge clk);
        for (int i = 0; i < WD; i++) begin
            repeat (CS) @(negedge clk);
            d[i] = o_tx;
        end
        if (m != 2'b00) begin
            repeat (CS) @(negedge clk);
            pb = o_tx;
        end
        repeat (CS) @(negedge clk);
        sb = o_tx;
    endtask

    task automatic drive_frame(input logic [WD-1:0] d, input logic [1:0] m,
                               input logic bad_par, input logic stop_v);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (CS) @(negedge clk);
        for (int i = 0; i < WD; i++) begin
            rx_drv = d[i];
            repeat (CS) @(negedge clk);
        end
        if (m != 2'b00) begin
            rx_drv = ref_par(m, d) ^ bad_par;
            repeat (CS) @(negedge clk);
        end
        rx_drv = stop_v;
        repeat (CS * NS) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * CS) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        n_checks++; if (o_tx !== 1'b1)   begin n_fail++; $display("FAIL reset_tx: got %b want 1", o_tx); end
        n_checks++; if (o_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", o_full); end
        n_checks++; if (o_mty !== 1'b1)  begin n_fail++; $display("FAIL reset_mty: got %b want 1", o_mty); end
        n_checks++; if (o_rdy !== 1'b0)  begin n_fail++; $display("FAIL reset_rdy: got %b want 0", o_rdy); end
        n_checks++; if (o_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", o_data); end
        n_checks++; if ({o_perr, o_ferr, o_ovr} !== 3'b000)
            begin n_fail++; $display("FAIL reset_flags: got %b want 000", {o_perr, o_ferr, o_ovr}); end
    endtask

    task automatic test_tx_timing();
        int fall_c, n;
        rx_src = 1'b0; i_par = 2'b01;
        @(negedge clk); i_data = 8'h96; i_we = 1'b1;
        @(posedge clk); #1; i_we = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (o_mty !== 1'b0) begin n_fail++; $display("FAIL tx_mty_n1: got %b want 0", o_mty); end
        n_checks++; if (o_tx !== 1'b1)  begin n_fail++; $display("FAIL tx_line_n1: got %b want 1", o_tx); end
        @(posedge clk); #1;
        n_checks++; if (o_tx !== 1'b0)  begin n_fail++; $display("FAIL tx_start_n2: got %b want 0", o_tx); end
        fall_c = cyc;
        n = 0;
        while (o_mty !== 1'b1 && n < 1000) begin @(posedge clk); #1; n++; end
        n_checks++; if (cyc - fall_c != frame_len(2'b01))
            begin n_fail++; $display("FAIL tx_frame_len: got %0d want %0d", cyc - fall_c, frame_len(2'b01)); end
    endtask

    task automatic test_fifo_fill();
        logic [WD-1:0] d; logic pb, sb, to, saw_low;
        int sc, prev, n;
        i_par = 2'b00;
        @(negedge clk);
        for (int k = 1; k <= DEP + 1; k++) begin
            i_data = 8'(k); i_we = 1'b1;
            @(negedge clk);
            if (k == DEP) begin
                n_checks++; if (o_full !== 1'b1) begin n_fail++; $display("FAIL fill_full4: got %b want 1", o_full); end
            end
        end
        i_we = 1'b0;
        n_checks++; if (o_full !== 1'b1) begin n_fail++; $display("FAIL fill_full5: got %b want 1", o_full); end
        prev = 0;
        for (int k = 1; k <= DEP; k++) begin
            rx_line(2'b00, d, pb, sb, sc, to);
            n_checks++; if (to || d !== 8'(k) || sb !== 1'b1)
                begin n_fail++; $display("FAIL fill_frame%0d: got %h stop %b to %b want %h", k, d, sb, to, k); end
            if (k >= 3) begin
                n_checks++; if (sc - prev != frame_len(2'b00))
                    begin n_fail++; $display("FAIL fill_gap%0d: got %0d want %0d", k, sc - prev, frame_len(2'b00)); end
            end
            prev = sc;
        end
        n = 0;
        while (o_mty !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        n_checks++; if (o_mty !== 1'b1) begin n_fail++; $display("FAIL fill_mty: got %b want 1", o_mty); end
        saw_low = 1'b0;
        repeat (2 * frame_len(2'b00)) begin @(negedge clk); if (o_tx !== 1'b1) saw_low = 1'b1; end
        n_checks++; if (saw_low !== 1'b0) begin n_fail++; $display("FAIL fill_drop5: got line activity %b want 0", saw_low); end
    endtask

    task automatic test_loopback_even();
        logic [WD-1:0] d; logic pb, sb, to;
        int sc;
        rx_src = 1'b1; i_par = 2'b01;
        write_byte(8'hA5);
        rx_line(2'b01, d, pb, sb, sc, to);
        n_checks++; if (to || d !== 8'hA5) begin n_fail++; $display("FAIL lb_line_data: got %h want a5", d); end
        n_checks++; if (pb !== 1'b0) begin n_fail++; $display("FAIL lb_par_bit: got %b want 0", pb); end
        wait_rdy();
        n_checks++; if (o_rdy !== 1'b1 || o_data !== 8'hA5)
            begin n_fail++; $display("FAIL lb_rx_data: got rdy %b data %h want 1 a5", o_rdy, o_data); end
        n_checks++; if ({o_perr, o_ferr, o_ovr} !== 3'b000)
            begin n_fail++; $display("FAIL lb_flags: got %b want 000", {o_perr, o_ferr, o_ovr}); end
        pop_rx();
        n_checks++; if (o_rdy !== 1'b0) begin n_fail++; $display("FAIL lb_pop: got %b want 0", o_rdy); end
    endtask

    task automatic test_loopback_random();
        logic [WD-1:0] d, dl, e; logic [1:0] m; logic pb, sb, to;
        int sc;
        rx_src = 1'b1;
        for (int k = 0; k < 6; k++) begin
            m = 2'($urandom_range(0, 3));
            d = 8'($urandom_range(0, 255));
            i_par = m;
            write_byte(d);
            exp_q.push_back(d);
            fork
                rx_line(m, dl, pb, sb, sc, to);
                begin repeat (3 * CS) @(negedge clk); i_par = 2'($urandom_range(0, 3)); end
            join
            n_checks++; if (to || dl !== d || sb !== 1'b1)
                begin n_fail++; $display("FAIL rnd_line%0d: got %h stop %b want %h", k, dl, sb, d); end
            if (m != 2'b00) begin
                n_checks++; if (pb !== ref_par(m, d))
                    begin n_fail++; $display("FAIL rnd_par%0d: got %b want %b mode %b", k, pb, ref_par(m, d), m); end
            end
            wait_rdy();
            e = exp_q.pop_front();
            n_checks++; if (o_rdy !== 1'b1 || o_data !== e)
                begin n_fail++; $display("FAIL rnd_rx%0d: got rdy %b data %h want %h", k, o_rdy, o_data, e); end
            n_checks++; if ({o_perr, o_ferr, o_ovr} !== 3'b000)
                begin n_fail++; $display("FAIL rnd_flags%0d: got %b want 000", k, {o_perr, o_ferr, o_ovr}); end
            pop_rx();
        end
    endtask

    task automatic test_parity_err();
        logic [WD-1:0] d;
        rx_src = 1'b0; i_par = 2'b10;
        clear_err();
        drive_frame(8'h3C, 2'b10, 1'b1, 1'b1);
        n_checks++; if (o_rdy !== 1'b1 || o_data !== 8'h3C)
            begin n_fail++; $display("FAIL perr_data: got rdy %b data %h want 1 3c", o_rdy, o_data); end
        n_checks++; if (o_perr !== 1'b1 || o_ferr !== 1'b0)
            begin n_fail++; $display("FAIL perr_set: got perr %b ferr %b want 1 0", o_perr, o_ferr); end
        repeat (40) @(negedge clk);
        n_checks++; if (o_perr !== 1'b1) begin n_fail++; $display("FAIL perr_sticky: got %b want 1", o_perr); end
        clear_err();
        n_checks++; if (o_perr !== 1'b0) begin n_fail++; $display("FAIL perr_clear: got %b want 0", o_perr); end
        pop_rx();
        d = 8'($urandom_range(0, 255));
        drive_frame(d, 2'b10, 1'b0, 1'b1);
        n_checks++; if (o_rdy !== 1'b1 || o_data !== d || o_perr !== 1'b0)
            begin n_fail++; $display("FAIL perr_good: got %h perr %b want %h 0", o_data, o_perr, d); end
        pop_rx();
    endtask

    task automatic test_framing();
        logic [WD-1:0] d;
        rx_src = 1'b0; i_par = 2'b00;
        d = 8'($urandom_range(0, 255));
        drive_frame(d, 2'b00, 1'b0, 1'b0);
        n_checks++; if (o_ferr !== 1'b1) begin n_fail++; $display("FAIL ferr_set: got %b want 1", o_ferr); end
        n_checks++; if (o_rdy !== 1'b1 || o_data !== d)
            begin n_fail++; $display("FAIL ferr_push: got rdy %b data %h want 1 %h", o_rdy, o_data, d); end
        clear_err();
        pop_rx();
        @(negedge clk); rx_drv = 1'b0;
        repeat (CS / 2 - 3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (3 * CS) @(negedge clk);
        n_checks++; if (o_rdy !== 1'b0) begin n_fail++; $display("FAIL glitch_push: got %b want 0", o_rdy); end
        n_checks++; if ({o_perr, o_ferr, o_ovr} !== 3'b000)
            begin n_fail++; $display("FAIL glitch_flags: got %b want 000", {o_perr, o_ferr, o_ovr}); end
    endtask

    task automatic test_overrun();
        logic [WD-1:0] d, e;
        rx_src = 1'b0; i_par = 2'b01;
        clear_err();
        for (int k = 0; k <= DEP; k++) begin
            d = 8'($urandom_range(0, 255));
            if (k < DEP) exp_q.push_back(d);
            drive_frame(d, 2'b01, 1'b0, 1'b1);
        end
        n_checks++; if (o_ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", o_ovr); end
        for (int k = 0; k < DEP; k++) begin
            e = exp_q.pop_front();
            n_checks++; if (o_rdy !== 1'b1 || o_data !== e)
                begin n_fail++; $display("FAIL ovr_entry%0d: got rdy %b data %h want %h", k, o_rdy, o_data, e); end
            pop_rx();
        end
        n_checks++; if (o_rdy !== 1'b0) begin n_fail++; $display("FAIL ovr_lost: got rdy %b want 0", o_rdy); end
    endtask

    task automatic test_reset_midframe();
        logic [WD-1:0] d; logic pb, sb, to;
        int sc, n;
        rx_src = 1'b1; i_par = 2'b01;
        write_byte(8'h5A);
        n = 0;
        while (o_tx !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        repeat (3 * CS + 5) @(negedge clk);
        #3; nrst = 1'b0;
        #1;
        n_checks++; if (o_tx !== 1'b1 || o_mty !== 1'b1)
            begin n_fail++; $display("FAIL rst_async: got tx %b mty %b want 1 1", o_tx, o_mty); end
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (2 * frame_len(2'b01)) @(negedge clk);
        n_checks++; if (o_rdy !== 1'b0 || o_mty !== 1'b1)
            begin n_fail++; $display("FAIL rst_discard: got rdy %b mty %b want 0 1", o_rdy, o_mty); end
        write_byte(8'hC3);
        rx_line(2'b01, d, pb, sb, sc, to);
        n_checks++; if (to || d !== 8'hC3 || pb !== ref_par(2'b01, 8'hC3) || sb !== 1'b1)
            begin n_fail++; $display("FAIL rst_clean_line: got %h par %b stop %b want c3", d, pb, sb); end
        wait_rdy();
        n_checks++; if (o_rdy !== 1'b1 || o_data !== 8'hC3 || {o_perr, o_ferr, o_ovr} !== 3'b000)
            begin n_fail++; $display("FAIL rst_clean_rx: got rdy %b data %h flags %b want 1 c3 000",
                                     o_rdy, o_data, {o_perr, o_ferr, o_ovr}); end
        pop_rx();
    endtask

    initial begin
        test_reset();
        test_tx_timing();
        test_fifo_fill();
        test_loopback_even();
        test_loopback_random();
        test_parity_err();
        test_framing();
        test_overrun();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
